// File: rtl/mem_arbiter_if.sv
// Request, response and memory-port signals shared by the fetch/data requesters,
// the arbiter and the memory.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_data;

  logic        i_d_req;
  logic        i_d_write;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [1:0]  i_d_size;
  logic        o_d_gnt;
  logic        o_d_valid;
  logic        o_d_err;
  logic [31:0] o_d_rdata;

  logic        o_m_en;
  logic        o_m_write;
  logic [31:0] o_m_addr;
  logic [31:0] o_m_wdata;
  logic [3:0]  o_m_be;
  logic [31:0] i_m_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_d_req, i_d_write, i_d_addr, i_d_wdata, i_d_size, i_m_rdata,
    output o_if_gnt, o_if_valid, o_if_data, o_d_gnt, o_d_valid, o_d_err, o_d_rdata,
    output o_m_en, o_m_write, o_m_addr, o_m_wdata, o_m_be
  );

  modport master (
    output i_if_req, i_if_addr, i_d_req, i_d_write, i_d_addr, i_d_wdata, i_d_size, i_m_rdata,
    input  o_if_gnt, o_if_valid, o_if_data, o_d_gnt, o_d_valid, o_d_err, o_d_rdata,
    input  o_m_en, o_m_write, o_m_addr, o_m_wdata, o_m_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between an
// instruction-fetch requester and a byte/half/word data requester.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  typedef struct packed {
    logic       sel_d;
    logic       write;
    logic       err;
    logic [1:0] lane;
    logic [1:0] size;
  } txn_t;

  state_t           state, state_nxt;
  txn_t             txn, txn_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_d, last_d_nxt;
  logic             pick_d;
  logic [31:0]      req_addr;

  logic        if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt, d_err_nxt;
  logic        m_en_nxt, m_write_nxt;
  logic [31:0] if_data_nxt, d_rdata_nxt, m_addr_nxt, m_wdata_nxt;
  logic [3:0]  m_be_nxt;

  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      2'b01:   misaligned = 1'b0;
      2'b10:   misaligned = lane[0];
      2'b11:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      2'b01:   store_be = 4'b0001 << lane;
      2'b10:   store_be = 4'b0011 << {lane[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size);
    logic [31:0] tmp;
    tmp = word >> {lane, 3'b000};
    case (size)
      2'b01:   load_align = {24'h0, tmp[7:0]};
      2'b10:   load_align = {16'h0, tmp[15:0]};
      default: load_align = tmp;
    endcase
  endfunction

  // Tie goes to whichever requester was not granted last.
  assign pick_d   = bus.i_d_req & (~bus.i_if_req | ~last_d);
  assign req_addr = pick_d ? bus.i_d_addr : bus.i_if_addr;

  always_comb begin
    state_nxt    = state;
    txn_nxt      = txn;
    cnt_nxt      = cnt;
    last_d_nxt   = last_d;
    if_gnt_nxt   = 1'b0;
    if_valid_nxt = 1'b0;
    if_data_nxt  = '0;
    d_gnt_nxt    = 1'b0;
    d_valid_nxt  = 1'b0;
    d_err_nxt    = 1'b0;
    d_rdata_nxt  = '0;
    m_en_nxt     = 1'b0;
    m_write_nxt  = 1'b0;
    m_addr_nxt   = '0;
    m_wdata_nxt  = '0;
    m_be_nxt     = '0;

    case (state)
      IDLE: begin
        if (bus.i_if_req || bus.i_d_req) begin
          txn_nxt.sel_d = pick_d;
          txn_nxt.write = pick_d & bus.i_d_write;
          txn_nxt.lane  = req_addr[1:0];
          txn_nxt.size  = pick_d ? bus.i_d_size : 2'b11;
          txn_nxt.err   = pick_d & misaligned(bus.i_d_addr[1:0], bus.i_d_size);
          last_d_nxt    = pick_d;
          if_gnt_nxt    = ~pick_d;
          d_gnt_nxt     = pick_d;
          if (!txn_nxt.err) begin
            m_en_nxt    = 1'b1;
            m_write_nxt = txn_nxt.write;
            m_addr_nxt  = {req_addr[31:2], 2'b00};
            m_be_nxt    = txn_nxt.write ? store_be(txn_nxt.lane, txn_nxt.size) : 4'b1111;
            m_wdata_nxt = txn_nxt.write ? (bus.i_d_wdata << {txn_nxt.lane, 3'b000}) : 32'h0;
          end
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (txn.err) begin
          d_valid_nxt = 1'b1;
          d_err_nxt   = 1'b1;
          state_nxt   = RESP;
        end else begin
          cnt_nxt   = CNT_W'(LATENCY);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        // Last wait cycle: read data is on i_m_rdata now.
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
          if (txn.sel_d) begin
            d_valid_nxt = 1'b1;
            d_rdata_nxt = txn.write ? 32'h0 : load_align(bus.i_m_rdata, txn.lane, txn.size);
          end else begin
            if_valid_nxt = 1'b1;
            if_data_nxt  = bus.i_m_rdata;
          end
        end
      end
      RESP: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      txn            <= '0;
      cnt            <= '0;
      last_d         <= 1'b1;
      bus.o_if_gnt   <= 1'b0;
      bus.o_if_valid <= 1'b0;
      bus.o_if_data  <= '0;
      bus.o_d_gnt    <= 1'b0;
      bus.o_d_valid  <= 1'b0;
      bus.o_d_err    <= 1'b0;
      bus.o_d_rdata  <= '0;
      bus.o_m_en     <= 1'b0;
      bus.o_m_write  <= 1'b0;
      bus.o_m_addr   <= '0;
      bus.o_m_wdata  <= '0;
      bus.o_m_be     <= '0;
    end else begin
      state          <= state_nxt;
      txn            <= txn_nxt;
      cnt            <= cnt_nxt;
      last_d         <= last_d_nxt;
      bus.o_if_gnt   <= if_gnt_nxt;
      bus.o_if_valid <= if_valid_nxt;
      bus.o_if_data  <= if_data_nxt;
      bus.o_d_gnt    <= d_gnt_nxt;
      bus.o_d_valid  <= d_valid_nxt;
      bus.o_d_err    <= d_err_nxt;
      bus.o_d_rdata  <= d_rdata_nxt;
      bus.o_m_en     <= m_en_nxt;
      bus.o_m_write  <= m_write_nxt;
      bus.o_m_addr   <= m_addr_nxt;
      bus.o_m_wdata  <= m_wdata_nxt;
      bus.o_m_be     <= m_be_nxt;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, memory read latency in cycles from o_m_en to valid i_m_rdata; legal range 1..4.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_if_req  in  1  instruction-fetch request; held with i_if_addr until o_if_gnt.
REQ-005 i_if_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 o_if_gnt  out  1  one-cycle pulse, fetch request accepted.
REQ-007 o_if_valid  out  1  one-cycle pulse, o_if_data valid.
REQ-008 o_if_data  out  32  fetched instruction word.
REQ-009 i_d_req  in  1  data request; held with payload until o_d_gnt.
REQ-010 i_d_write  in  1  1 = store, 0 = load.
REQ-011 i_d_addr  in  32  data byte address.
REQ-012 i_d_wdata  in  32  store data, right-aligned.
REQ-013 i_d_size  in  2  01 byte, 10 half, 11 word, 00 illegal.
REQ-014 o_d_gnt  out  1  one-cycle pulse, data request accepted.
REQ-015 o_d_valid  out  1  one-cycle pulse, load data ready or store done.
REQ-016 o_d_err  out  1  qualifies o_d_valid; misaligned or illegal-size access.
REQ-017 o_d_rdata  out  32  load data, right-aligned (addressed byte/half in low bits), no extension.
REQ-018 o_m_en, o_m_write  out  1 each  memory access strobe (one cycle), write qualifier.
REQ-019 o_m_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-020 o_m_wdata, o_m_be  out  32, 4  lane-shifted store data, byte enables.
REQ-021 i_m_rdata  in  32  memory read word, valid LATENCY cycles after o_m_en.

Function
REQ-022 FSM states IDLE, ACCESS, WAIT, RESP; all outputs registered.
REQ-023 IDLE with any request: select winner, latch its payload, pulse its gnt next cycle, enter ACCESS.
REQ-024 Both requesting in same IDLE cycle: grant requester not granted most recently (round-robin); single requester granted unconditionally.
REQ-025 ACCESS (cycle T): o_m_en=1 exactly one cycle with o_m_addr/o_m_write/o_m_wdata/o_m_be from latched payload; gnt pulse coincides with cycle T.
REQ-026 WAIT: down-counter loaded with LATENCY at T; i_m_rdata sampled at end of cycle T+LATENCY.
REQ-027 RESP (cycle T+LATENCY+1): winner's valid pulses one cycle with sampled data; state IDLE next cycle; new request earliest o_m_en at T+LATENCY+3.
REQ-028 Stores traverse the same timing; o_d_valid pulses at T+LATENCY+1, o_d_rdata = 0.
REQ-029 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads and fetches 4'b1111.
REQ-030 Store data: o_m_wdata = i_d_wdata << (8*addr[1:0]); load data: o_d_rdata = i_m_rdata >> (8*addr[1:0]), masked to size.
REQ-031 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 00: gnt pulses, no o_m_en, state goes directly to RESP next cycle, o_d_valid=1 with o_d_err=1, o_d_rdata=0.
REQ-032 Fetch path never errors; o_if_data = i_m_rdata unshifted.
REQ-033 Requests asserted while not IDLE are held off (no gnt) until IDLE; round-robin pointer updates only on grant.

Reset
REQ-034 i_rst=1 at an edge: state IDLE, counter 0, all outputs 0, round-robin pointer = data-last (fetch wins first tie).
REQ-035 Reset mid-transaction abandons it; no valid pulse for the aborted access after reset deasserts.

Verification
REQ-036 LATENCY=1, fetch only, addr 0x0000_0104, mem returns 0x0000_0013: o_m_en at T with o_m_addr 0x104, o_if_valid at T+2 with 0x13.
REQ-037 Both request at reset exit: fetch granted first, data second; third simultaneous tie -> fetch.
REQ-038 Byte store addr 0x...03, wdata 0xAB: o_m_be 4'b1000, o_m_wdata 0xAB00_0000, o_d_valid with o_d_err=0.
REQ-039 Half load addr 0x...02, mem 0xBEEF_1234: o_d_rdata 0x0000_BEEF; word load addr 0x...01: no o_m_en, o_d_err=1.
REQ-040 LATENCY=3: valid exactly 4 cycles after o_m_en; i_rst asserted in WAIT -> no valid, all outputs 0 following edge.
